alu_seq: RTL and testbench

//  Parametrised, clocked successor to the 4-bit combinational ALU: WIDTH-bit operands, 3-bit opcode, registered result/flags.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and its multiply core.
package alu_seq_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_AND = 3'd2;
    localparam logic [OPW-1:0] OP_OR  = 3'd3;
    localparam logic [OPW-1:0] OP_XOR = 3'd4;
    localparam logic [OPW-1:0] OP_SHL = 3'd5;
    localparam logic [OPW-1:0] OP_SHR = 3'd6;
    localparam logic [OPW-1:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply core: start loads operands, WIDTH right-shift iterations,
// then a one-cycle done pulse with the 2*WIDTH product held in product.
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     acc;

    // Upper half accumulates the multiplicand when the current multiplier LSB is set;
    // the extra bit is the carry that shifts down into the product on this iteration.
    assign acc = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            prod_d = {acc, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Clocked WIDTH-bit ALU with valid/ready on both sides, one operation in flight.
// Macro ALU_SEQ_MUL_EN builds the multi-cycle multiplier; otherwise opcode 7 yields zero.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             C0,
    output logic             ZF,
    output logic [WIDTH-1:0] HI
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             c0_q, c0_d;
    logic             zf_q, zf_d;
    logic             accept;
    logic [WIDTH-1:0] alu_c;
    logic             alu_c0;
    logic [WIDTH:0]   sum, diff;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Borrow of the subtraction falls out as the top bit of the zero-extended difference.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        alu_c  = '0;
        alu_c0 = 1'b0;
        case (S)
            OP_ADD: begin alu_c = sum[WIDTH-1:0];  alu_c0 = sum[WIDTH];  end
            OP_SUB: begin alu_c = diff[WIDTH-1:0]; alu_c0 = diff[WIDTH]; end
            OP_AND: alu_c = A & B;
            OP_OR:  alu_c = A | B;
            OP_XOR: alu_c = A ^ B;
            OP_SHL: begin alu_c = {A[WIDTH-2:0], 1'b0}; alu_c0 = A[WIDTH-1]; end
            OP_SHR: begin alu_c = {1'b0, A[WIDTH-1:1]}; alu_c0 = A[0];       end
            default: begin alu_c = '0; alu_c0 = 1'b0; end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_done;
    logic               mul_start;

    assign mul_start = accept && (S == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        c0_d    = c0_q;
        zf_d    = zf_q;
`ifdef ALU_SEQ_MUL_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (S == OP_MUL) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                        c_d     = alu_c;
                        c0_d    = alu_c0;
                        zf_d    = (alu_c == '0);
                        hi_d    = '0;
                    end
`else
                    state_d = ST_DONE;
                    c_d     = alu_c;
                    c0_d    = alu_c0;
                    zf_d    = (alu_c == '0);
`endif
                end
            end
            ST_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                if (mul_done) begin
                    state_d = ST_DONE;
                    c_d     = mul_prod[WIDTH-1:0];
                    hi_d    = mul_prod[2*WIDTH-1:WIDTH];
                    c0_d    = |mul_prod[2*WIDTH-1:WIDTH];
                    zf_d    = (mul_prod[WIDTH-1:0] == '0);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            c0_q    <= 1'b0;
            zf_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            c0_q    <= c0_d;
            zf_q    <= zf_d;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign C         = c_q;
    assign C0        = c0_q;
    assign ZF        = zf_q;
`ifdef ALU_SEQ_MUL_EN
    assign HI        = hi_q;
`else
    assign HI        = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed and exhaustive bench for alu_seq (WIDTH=4) against an arithmetic reference model.
module tb_alu_seq;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   S = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, C0, ZF;
    logic [W-1:0] C, HI;

    int checks = 0;
    int failures = 0;

    // expectation for the operation currently in flight
    int m_c, m_c0, m_zf, m_hi, m_lat;
    bit m_have = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .C0        (C0),
        .ZF        (ZF),
        .HI        (HI)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int c, output int c0, output int zf,
                                  output int hi, output int lat);
        int p;
        c = 0; c0 = 0; hi = 0; lat = 1;
        case (op)
            0: begin p = a + b; c = p % MOD; c0 = (p >= MOD) ? 1 : 0; end
            1: begin c = (a - b + MOD) % MOD; c0 = (a < b) ? 1 : 0; end
            2: c = a & b;
            3: c = a | b;
            4: c = a ^ b;
            5: begin c = (a * 2) % MOD; c0 = (a >= MOD / 2) ? 1 : 0; end
            6: begin c = a / 2; c0 = a % 2; end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                p = a * b; c = p % MOD; hi = p / MOD; c0 = (hi != 0) ? 1 : 0; lat = W + 1;
`else
                c = 0;
`endif
            end
        endcase
        zf = (c == 0) ? 1 : 0;
    endfunction

    // Whenever a result is presented it must match the model and hold while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!m_have) begin
                checks++;
                failures++;
                $display("FAIL spurious_out_valid actual=1 expected=0 (t=%0t)", $time);
            end else begin
                chk("cmp_C", int'(C), m_c);
                chk("cmp_C0", int'(C0), m_c0);
                chk("cmp_ZF", int'(ZF), m_zf);
                chk("cmp_HI", int'(HI), m_hi);
                chk("cmp_in_ready_done", int'(in_ready), 0);
            end
        end
    end

    task automatic do_op(input int op, input int a, input int b, input int stall,
                         input bit hold, input bit lit, input int lc, input int lc0,
                         input int lzf, input int lhi);
        int n;
        @(negedge clk);
        chk("in_ready_idle", int'(in_ready), 1);
        S = op[2:0]; A = a[W-1:0]; B = b[W-1:0];
        in_valid = 1'b1; out_ready = 1'b0;
        model(op, a, b, m_c, m_c0, m_zf, m_hi, m_lat);
        @(posedge clk); #1;
        m_have = 1'b1;
        if (!hold) in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom);
        n = 1;
        while (!out_valid && n <= 20) begin
            if (hold) chk("in_ready_busy", int'(in_ready), 0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, m_lat);
        if (lit) begin
            chk("lit_C", int'(C), lc);
            chk("lit_C0", int'(C0), lc0);
            chk("lit_ZF", int'(ZF), lzf);
            chk("lit_HI", int'(HI), lhi);
        end
        repeat (stall) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        m_have = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_C", int'(C), 0);
        chk("rst_C0", int'(C0), 0);
        chk("rst_ZF", int'(ZF), 0);
        chk("rst_HI", int'(HI), 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_release_in_ready", int'(in_ready), 1);

        // ADD overflow wraps to zero
        do_op(0, 15, 1, 0, 0, 1, 0, 1, 1, 0);
        // SUB borrow and equal operands
        do_op(1, 3, 5, 0, 0, 1, 14, 1, 0, 0);
        do_op(1, 5, 5, 0, 0, 1, 0, 0, 1, 0);
        // MUL with in_valid held through BUSY
`ifdef ALU_SEQ_MUL_EN
        do_op(7, 13, 11, 0, 1, 1, 15, 1, 0, 8);
        do_op(7, 0, 9, 0, 0, 1, 0, 0, 1, 0);
`else
        do_op(7, 13, 11, 0, 1, 1, 0, 0, 1, 0);
`endif
        // SHL under 4 cycles of backpressure
        do_op(5, 9, 6, 4, 0, 1, 2, 1, 0, 0);

        // reset two cycles into a MUL (or while its result waits, without the multiplier)
        @(negedge clk);
        S = 3'd7; A = 4'd13; B = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
        model(7, 13, 11, m_c, m_c0, m_zf, m_hi, m_lat);
        @(posedge clk); #1;
        m_have = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; m_have = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_C", int'(C), 0);
        chk("abort_C0", int'(C0), 0);
        chk("abort_ZF", int'(ZF), 0);
        chk("abort_HI", int'(HI), 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("abort_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        chk("abort_no_result", int'(out_valid), 0);

        for (int op = 0; op < 8; op++)
            for (int a = 0; a < MOD; a++)
                for (int b = 0; b < MOD; b++)
                    do_op(op, a, b, int'($urandom_range(0, 2)), 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
